// File: rtl/ifu_pc_gen_if.sv
// Fetch-side bundle between the PC generator and the instruction-fetch / decode path.
interface ifu_pc_gen_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              pvalid;
  logic              iready;
  logic              ivalid;
  logic              dready;
  logic [ADDR_W-1:0] inst_pc;
  logic              kill;

  modport master (
    output pc, pvalid, inst_pc, kill,
    input  iready, ivalid, dready
  );

  modport slave (
    input  pc, pvalid, inst_pc, kill,
    output iready, ivalid, dready
  );
endinterface

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: one outstanding fetch, sequential advance, EXU redirects with kill tagging.
// Optional macro PCGEN_TRAP_EN adds trap_valid/trap_vec, a redirect with priority over redirect_valid.
module ifu_pc_gen #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000),
  parameter int unsigned       INST_B   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef PCGEN_TRAP_EN
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_vec,
`endif
  ifu_pc_gen_if.master      fetch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              pvalid_q;
  logic              kill_q;

  logic              redir;
  logic [ADDR_W-1:0] redir_raw;
  logic [ADDR_W-1:0] redir_target;
  logic [ADDR_W-1:0] pc_inc;
  logic              ret;

`ifdef PCGEN_TRAP_EN
  assign redir     = trap_valid | redirect_valid;
  assign redir_raw = trap_valid ? trap_vec : redirect_pc;
`else
  assign redir     = redirect_valid;
  assign redir_raw = redirect_pc;
`endif

  // Targets are word aligned; low two bits are dropped.
  assign redir_target = redir_raw & ~ADDR_W'(3);
  assign pc_inc       = pc_q + ADDR_W'(INST_B);
  assign ret          = fetch.ivalid & fetch.dready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      inst_pc_q <= '0;
      pvalid_q  <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redir) begin
            pc_q <= redir_target;
          end else if (!stall) begin
            pvalid_q <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          if (fetch.iready) begin
            inst_pc_q <= pc_q;
            pvalid_q  <= 1'b0;
            // A redirect landing on the accept cycle makes the accepted fetch stale.
            if (redir) begin
              pc_q   <= redir_target;
              kill_q <= 1'b1;
              state  <= FLUSH;
            end else begin
              state <= WAIT;
            end
          end else begin
            if (redir) pc_q <= redir_target;
            if (stall) begin
              pvalid_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        WAIT: begin
          if (redir) begin
            pc_q <= redir_target;
            // Coincident retire is the branch itself, so it stays valid.
            if (ret) begin
              state <= IDLE;
            end else begin
              kill_q <= 1'b1;
              state  <= FLUSH;
            end
          end else if (ret) begin
            pc_q  <= pc_inc;
            state <= IDLE;
          end
        end

        FLUSH: begin
          if (redir) pc_q <= redir_target;
          if (ret) begin
            kill_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign fetch.pc      = pc_q;
  assign fetch.pvalid  = pvalid_q;
  assign fetch.inst_pc = inst_pc_q;
  assign fetch.kill    = kill_q;

endmodule
